// File: rtl/cache_sim_pkg.sv
// Shared types for the stream prefetch buffer: FSM states, buffer entry
// layout and line-geometry helpers.
package cache_sim_pkg;

  // Entry line field is sized for the widest supported line address; the
  // buffer stores lines zero-extended so compares stay exact.
  localparam int LINE_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    CHECK,
    REQ
  } pf_state_t;

  typedef struct packed {
    logic                  valid;
    logic [LINE_MAX_W-1:0] line;
  } pf_entry_t;

  function automatic int pf_offset_w(input int block_size_byte);
    return $clog2(block_size_byte);
  endfunction

  function automatic int pf_line_w(input int addr_w, input int block_size_byte);
    return addr_w - $clog2(block_size_byte);
  endfunction

endpackage

// File: rtl/pf_match_array.sv
// Parallel compare of one line address against every buffer entry, plus
// lowest-index free-slot search. Purely combinational.
module pf_match_array
  import cache_sim_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3
) (
  input  pf_entry_t [ENTRIES-1:0] entries_i,
  input  logic [LINE_MAX_W-1:0]   line_i,
  output logic                    match_o,
  output logic [IDX_W-1:0]        match_idx_o,
  output logic                    any_invalid_o,
  output logic [IDX_W-1:0]        first_invalid_idx_o
);

  // Scan high to low so the lowest index wins for the free-slot search.
  always_comb begin
    match_o             = 1'b0;
    match_idx_o         = '0;
    any_invalid_o       = 1'b0;
    first_invalid_idx_o = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entries_i[i].valid && (entries_i[i].line == line_i)) begin
        match_o     = 1'b1;
        match_idx_o = IDX_W'(i);
      end
      if (!entries_i[i].valid) begin
        any_invalid_o       = 1'b1;
        first_invalid_idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/stream_prefetch_buffer.sv
// Next-N-line stream prefetcher with a fully-associative buffer of
// prefetched lines. Optional statistics counters are built only when
// STREAM_PF_STATS_EN is defined; otherwise hit_count/miss_count are tied 0.
module stream_prefetch_buffer
  import cache_sim_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int ENTRIES         = 8,
  parameter int DEGREE          = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              busy,
  output logic              pf_hit,
  output logic              pf_miss,
  output logic              pf_req_valid,
  output logic [ADDR_W-1:0] pf_req_addr,
  input  logic              pf_req_ready,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int OFFSET_W = pf_offset_w(BLOCK_SIZE_BYTE);
  localparam int LINE_W   = pf_line_w(ADDR_W, BLOCK_SIZE_BYTE);
  localparam int IDX_W    = $clog2(ENTRIES);
  localparam int D_W      = 3;

  pf_state_t                state_q, state_d;
  logic [LINE_W-1:0]        line_q, line_d;
  logic [D_W-1:0]           deg_q, deg_d;
  pf_entry_t [ENTRIES-1:0]  entries_q;
  logic [IDX_W-1:0]         victim_q;
  logic                     busy_q, pf_hit_q, pf_hit_d, pf_miss_q, pf_miss_d;
  logic                     req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]        req_addr_q, req_addr_d;
  logic                     inv_lookup, install;
  logic [IDX_W-1:0]         install_idx;

  logic [LINE_W-1:0]        cand;
  logic                     lk_match, lk_any_inv, ck_match, ck_any_inv;
  logic [IDX_W-1:0]         lk_idx, lk_first_inv, ck_idx, ck_first_inv;
  logic                     miss_offset_unused;

  assign cand               = line_q + LINE_W'(deg_q);
  assign miss_offset_unused = ^{miss_addr[OFFSET_W-1:0], lk_any_inv, lk_first_inv, ck_idx};

  pf_match_array #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_lookup (
    .entries_i           (entries_q),
    .line_i              (LINE_MAX_W'(line_q)),
    .match_o             (lk_match),
    .match_idx_o         (lk_idx),
    .any_invalid_o       (lk_any_inv),
    .first_invalid_idx_o (lk_first_inv)
  );

  pf_match_array #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_check (
    .entries_i           (entries_q),
    .line_i              (LINE_MAX_W'(cand)),
    .match_o             (ck_match),
    .match_idx_o         (ck_idx),
    .any_invalid_o       (ck_any_inv),
    .first_invalid_idx_o (ck_first_inv)
  );

  assign install_idx = ck_any_inv ? ck_first_inv : victim_q;

  // Next-state and registered-output logic for the lookup/prefetch sequence.
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    deg_d       = deg_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    pf_hit_d    = 1'b0;
    pf_miss_d   = 1'b0;
    inv_lookup  = 1'b0;
    install     = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_valid) begin
          line_d  = miss_addr[ADDR_W-1:OFFSET_W];
          deg_d   = D_W'(1);
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        pf_hit_d   = lk_match;
        pf_miss_d  = !lk_match;
        inv_lookup = lk_match;
        state_d    = CHECK;
      end
      CHECK: begin
        if (ck_match) begin
          deg_d = deg_q + D_W'(1);
          if (deg_q == D_W'(DEGREE)) state_d = IDLE;
        end else begin
          req_valid_d = 1'b1;
          req_addr_d  = {cand, {OFFSET_W{1'b0}}};
          state_d     = REQ;
        end
      end
      REQ: begin
        if (pf_req_ready) begin
          install     = 1'b1;
          req_valid_d = 1'b0;
          if (deg_q == D_W'(DEGREE)) begin
            state_d = IDLE;
          end else begin
            deg_d   = deg_q + D_W'(1);
            state_d = CHECK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs; reset drops any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      line_q      <= '0;
      deg_q       <= '0;
      busy_q      <= 1'b0;
      pf_hit_q    <= 1'b0;
      pf_miss_q   <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      deg_q       <= deg_d;
      busy_q      <= (state_d != IDLE);
      pf_hit_q    <= pf_hit_d;
      pf_miss_q   <= pf_miss_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
    end
  end

  // Buffer contents: invalidate on demand hit, install on request handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q <= '0;
      victim_q  <= '0;
    end else begin
      if (inv_lookup) entries_q[lk_idx].valid <= 1'b0;
      if (install) begin
        entries_q[install_idx].valid <= 1'b1;
        entries_q[install_idx].line  <= LINE_MAX_W'(cand);
        if (!ck_any_inv) victim_q <= victim_q + IDX_W'(1);
      end
    end
  end

  assign busy         = busy_q;
  assign pf_hit       = pf_hit_q;
  assign pf_miss      = pf_miss_q;
  assign pf_req_valid = req_valid_q;
  assign pf_req_addr  = req_addr_q;

`ifdef STREAM_PF_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating hit/miss counters, stepped alongside the pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (pf_hit_d && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (pf_miss_d && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: doc/stream_prefetch_buffer.md
# stream_prefetch_buffer

Parametrised next-N-line prefetcher for the cache simulator. On each demand miss it looks up a fully-associative buffer of prefetched line addresses and reports hit or miss. It then issues up to DEGREE sequential next-line prefetch requests over a valid/ready handshake, skipping lines already held. The block sits beside the L1 controller, between the cache's miss output and the memory-side request arbiter.

## Interface
- ADDR_W, 32, byte address width
- BLOCK_SIZE_BYTE, 16, line size; power of two, ≥ 4
- ENTRIES, 8, buffer entries; power of two, 2..32
- DEGREE, 2, next lines prefetched per miss, 1..4
- OFFSET_W, log2(BLOCK_SIZE_BYTE), derived
- LINE_W, ADDR_W-OFFSET_W, derived
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- miss_valid  in  1  demand miss strobe; accepted only when busy=0
- miss_addr  in  ADDR_W  demand miss byte address
- busy  out  1  high from the cycle after acceptance until return to IDLE
- pf_hit  out  1  one-cycle pulse: miss line found in buffer
- pf_miss  out  1  one-cycle pulse: miss line not in buffer
- pf_req_valid  out  1  prefetch request valid
- pf_req_addr  out  ADDR_W  line-aligned prefetch address (low OFFSET_W bits zero)
- pf_req_ready  in  1  memory side accepts request
- hit_count, miss_count  out  32 each  statistics (see Configuration)

## Operation
- Entry: valid bit plus LINE_W line address. Line = addr[ADDR_W-1:OFFSET_W].
- FSM states:
  - IDLE: on miss_valid, latch line L, set d=1, go to LOOKUP.
  - LOOKUP: compare L against all valid entries.
    - Match: pulse pf_hit and clear that entry's valid bit (the line moves into cache).
    - No match: pulse pf_miss.
    - Go to CHECK.
  - CHECK: candidate C = L+d, modulo 2^LINE_W (line 2^LINE_W-1 wraps to 0).
    - C already valid in buffer: skip; d++. Go to IDLE if d was DEGREE, else stay in CHECK.
    - C absent: go to REQ, drive pf_req_valid=1 and pf_req_addr={C, OFFSET_W'b0}.
  - REQ: hold valid and addr stable until pf_req_ready.
    - On handshake: install C, then deassert valid. Go to IDLE if d==DEGREE, else d++ and go to CHECK.
- Install target: lowest-index invalid entry. If none is invalid, the entry at the round-robin victim pointer; the pointer then advances, wrapping at ENTRIES-1.
- miss_valid while busy=1 is ignored (dropped, not queued). The miss controller must hold or retry.
- pf_hit and pf_miss are mutually exclusive. Exactly one pulses per accepted miss.

## Timing
- Reset: all entries invalid, victim pointer 0, state IDLE, every output 0 (busy, pf_hit, pf_miss, pf_req_valid, pf_req_addr, counters).
- Reset asserted mid-operation aborts any outstanding request immediately, with no install. pf_req_valid falls asynchronously.
- Accept at edge E0. pf_hit/pf_miss are registered at E1 and high for one cycle only.
- First CHECK runs in the cycle after E1. pf_req_valid is registered and is earliest high after E2.
- Each skipped candidate costs one cycle. Each issued request costs two cycles plus ready stall cycles.
- With DEGREE=2, both candidates absent, and ready tied high: handshakes at E3 and E5; busy=0 after E5; the next miss is accepted at E6.
- All outputs are registered. No combinational path from miss_addr or pf_req_ready to outputs.

## Configuration
- STREAM_PF_STATS_EN defined: hit_count and miss_count increment on each pf_hit and pf_miss pulse respectively, saturating at 0xFFFFFFFF. Reset clears both.
- Undefined: both ports are tied to 0 and no counter logic is synthesised. FSM behaviour is identical.

## Structure
- Package cache_sim_pkg holds:
  - pf_state_t enum (IDLE, LOOKUP, CHECK, REQ)
  - clog2-based OFFSET_W/LINE_W helper function
  - pf_entry_t struct {valid, line}
- Sub-module pf_match_array: combinational parallel compare of one line against all entries. Outputs match, match_idx, any_invalid, first_invalid_idx. It is instantiated twice: once for the LOOKUP compare, once for the CHECK candidate compare.

## Test plan
- Reset, then miss_addr=0x0000_1000: pf_miss pulses once; requests 0x1010 then 0x1020; busy drops after the second handshake.
- Repeat miss at 0x0000_1010 after the first test: pf_hit, entry 0x101 invalidated; 0x1020 skipped; single request 0x1030.
- miss_addr=0xFFFF_FFF4 with DEGREE=2: requests 0x0000_0000 then 0x0000_0010 (line wrap).
- Fill all 8 entries, then miss on a new stream: installs overwrite entries 0 and 1 in round-robin order; pointer reaches 2.
- Hold pf_req_ready low 5 cycles: pf_req_addr stable; miss_valid pulses meanwhile ignored; assert rst: pf_req_valid 0 in the same cycle, all entries invalid.
- With STREAM_PF_STATS_EN defined: 3 misses then 2 hits give miss_count=3, hit_count=2. Without the macro, both read 0.
